multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Moore-style control FSM for the multi-cycle RV32I core. It sequences one shared ALU, one unified instruction/data memory port and the register file across Fetch, Decode, Execute, Memory and Writeback states. It is driven by the opcode latched in the instruction register. It replaces the single-cycle opcode decoder for the multi-cycle build and stalls on a memory-ready handshake.

## Interface
- No parameters.
- clk  in  1  core clock, all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- op  in  7  opcode field from the instruction register (Instr[6:0])
- zero  in  1  ALU zero flag, sampled in BEQ
- mem_ready  in  1  memory handshake; the access completes in a cycle where it is 1
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address select: 0 = PC, 1 = Result
- mem_write  out  1  data memory write strobe
- ir_write  out  1  instruction register and OldPC enable
- result_src  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- alu_src_a  out  2  ALU operand A select: 00 = PC, 01 = OldPC, 10 = A register
- alu_src_b  out  2  ALU operand B select: 00 = B register, 01 = ImmExt, 10 = constant 4
- alu_op  out  2  ALU operation class: 00 = add, 01 = sub/branch, 10 = R-type, 11 = I-type
- imm_src  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- reg_write  out  1  register file write enable
- retire  out  1  one-cycle pulse in the final cycle of each instruction
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode

## Operation
- Supported opcodes:
  - 0000011 lw
  - 0100011 sw
  - 0110011 R-type
  - 0010011 I-type ALU
  - 1100011 beq
  - 1101111 jal (only when the macro is defined)
- imm_src is combinational from op: sw → 01, beq → 10, jal → 11, all others → 00.
- Internally pc_write = pc_update | (branch & zero).
- Each state lists its non-zero outputs, then its transition. All unlisted outputs are 0.
- FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write = pc_update = mem_ready.
  - Stay while mem_ready=0; go to DECODE when it is 1.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (computes the branch target into ALUOut).
  - lw/sw → MEMADR; R-type → EXECR; I-type → EXECI; beq → BEQ; jal → JAL.
  - Any other opcode: illegal_op=1, retire=1, go to FETCH (instruction executes as a NOP).
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00.
  - lw → MEMREAD; sw → MEMWRITE.
- MEMREAD: adr_src=1, result_src=00.
  - Stay until mem_ready=1, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1, retire=1. Go to FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1.
  - Hold while mem_ready=0.
  - On mem_ready=1: retire=1, go to FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10. Go to ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=11. Go to ALUWB.
- ALUWB: result_src=00, reg_write=1, retire=1. Go to FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1, retire=1.
  - pc_write = zero. Go to FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1. Go to ALUWB.
- Unreachable state encodings decode as FETCH outputs and go to FETCH on the next edge.

## Timing
- Reset (rst=0) asynchronously forces state to FETCH.
- While rst=0, pc_write, ir_write, mem_write, reg_write, retire and illegal_op are forced to 0.
- While rst=0, the other outputs hold their FETCH values: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10. imm_src follows op.
- Reset mid-instruction abandons that instruction; it does not retire.
- Outputs are combinational from the state register, op, zero and mem_ready. There are no output registers.
- Latency with mem_ready tied to 1:
  - lw 5 cycles
  - sw 4
  - R-type/I-type 4
  - beq 3
  - jal 4
  - illegal 2
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- During such a stall all outputs hold their state values, except that ir_write and pc_update are 0 in FETCH.
- mem_write stays asserted for the whole MEMWRITE stall.
- The memory must not complete a write twice.
- zero is sampled only in the BEQ cycle.

## Configuration
- MC_JAL_EN defined:
  - opcode 1101111 decodes to the JAL state.
  - imm_src=11 for that opcode.
  - rd ← PC+4 through ALUWB, and PC ← OldPC+imm taken from ALUOut in DECODE.
- MC_JAL_EN undefined:
  - the JAL state is not built.
  - 1101111 is illegal: illegal_op pulses and the instruction is a NOP.
  - imm_src for that opcode is 00.

## Test plan
- Reset: rst=0 mid-MEMWRITE with mem_ready=0 → mem_write drops to 0 immediately; after rst=1, state FETCH, first ir_write on the first cycle with mem_ready=1.
- lw (op=0000011), mem_ready=1 → sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write=1 and result_src=01 in cycle 5; retire once.
- sw with mem_ready low for 3 cycles in MEMWRITE → mem_write=1 for 4 cycles, adr_src=1, imm_src=01, retire only in the cycle where mem_ready=1.
- beq with zero=1 → pc_write=1 and alu_op=01 in cycle 3; with zero=0 → pc_write=0; reg_write=0 throughout; retire in both cases.
- R-type then I-type back-to-back → alu_op=10 then 11 in EXEC; reg_write in cycle 4 of each; 8 cycles total.
- op=1101111 → with MC_JAL_EN: 4 cycles, pc_write=1 in JAL, reg_write=1 in ALUWB; without it: illegal_op=1 in DECODE, back in FETCH in cycle 3.

Source files
------------

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multi-cycle RV32I core: sequences the shared ALU, unified memory port and register file.
// Optional JAL support is enabled by defining MC_JAL_EN; the default build treats opcode 1101111 as illegal.
//
// state      | meaning
// S_FETCH    | read instruction at PC, PC <= PC+4 when memory is ready
// S_DECODE   | read registers, compute branch/jump target into ALUOut
// S_MEMADR   | compute load/store address
// S_MEMREAD  | read data memory, wait for ready
// S_MEMWB    | write loaded data to rd
// S_MEMWRITE | write data memory, wait for ready
// S_EXECR    | R-type ALU operation
// S_EXECI    | I-type ALU operation
// S_ALUWB    | write ALUOut to rd
// S_BEQ      | compare and conditionally branch
// S_JAL      | PC <= target, ALU computes OldPC+4 (MC_JAL_EN only)

module multicycle_controller (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [6:0] i_op,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic       o_pc_write,
    output logic       o_adr_src,
    output logic       o_mem_write,
    output logic       o_ir_write,
    output logic [1:0] o_result_src,
    output logic [1:0] o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_alu_op,
    output logic [1:0] o_imm_src,
    output logic       o_reg_write,
    output logic       o_retire,
    output logic       o_illegal_op
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
`ifdef MC_JAL_EN
    localparam logic [6:0] OP_JAL  = 7'b1101111;
`endif

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9
`ifdef MC_JAL_EN
        , S_JAL    = 4'd10
`endif
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_adr_src;
    logic       w_mem_write;
    logic       w_ir_write;
    logic [1:0] w_result_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic       w_reg_write;
    logic       w_retire;
    logic       w_illegal_op;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_FETCH;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = S_FETCH;
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_adr_src    = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_result_src = 2'b00;
        w_alu_src_a  = 2'b00;
        w_alu_src_b  = 2'b00;
        w_alu_op     = 2'b00;
        w_reg_write  = 1'b0;
        w_retire     = 1'b0;
        w_illegal_op = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                w_ir_write   = i_mem_ready;
                w_pc_update  = i_mem_ready;
                w_next_state = i_mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
                case (i_op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_R:         w_next_state = S_EXECR;
                    OP_I:         w_next_state = S_EXECI;
                    OP_BEQ:       w_next_state = S_BEQ;
`ifdef MC_JAL_EN
                    OP_JAL:       w_next_state = S_JAL;
`endif
                    default: begin
                        w_illegal_op = 1'b1;
                        w_retire     = 1'b1;
                        w_next_state = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a  = 2'b10;
                w_alu_src_b  = 2'b01;
                w_next_state = (i_op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_adr_src    = 1'b1;
                w_next_state = i_mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
            end
            S_MEMWRITE: begin
                // Strobe held through the stall; leaving on ready guarantees a single completed write.
                w_adr_src    = 1'b1;
                w_mem_write  = 1'b1;
                w_retire     = i_mem_ready;
                w_next_state = i_mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                w_alu_src_a  = 2'b10;
                w_alu_op     = 2'b10;
                w_next_state = S_ALUWB;
            end
            S_EXECI: begin
                w_alu_src_a  = 2'b10;
                w_alu_src_b  = 2'b01;
                w_alu_op     = 2'b11;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
            end
            S_BEQ: begin
                w_alu_src_a = 2'b10;
                w_alu_op    = 2'b01;
                w_branch    = 1'b1;
                w_retire    = 1'b1;
            end
`ifdef MC_JAL_EN
            S_JAL: begin
                w_alu_src_a  = 2'b01;
                w_alu_src_b  = 2'b10;
                w_pc_update  = 1'b1;
                w_next_state = S_ALUWB;
            end
`endif
            default: begin
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                w_ir_write   = i_mem_ready;
                w_pc_update  = i_mem_ready;
                w_next_state = S_FETCH;
            end
        endcase
    end

    always_comb begin
        case (i_op)
            OP_SW:   o_imm_src = 2'b01;
            OP_BEQ:  o_imm_src = 2'b10;
`ifdef MC_JAL_EN
            OP_JAL:  o_imm_src = 2'b11;
`endif
            default: o_imm_src = 2'b00;
        endcase
    end

    // State is already FETCH during reset, so only the strobes need gating.
    assign o_pc_write   = i_rst_n & (w_pc_update | (w_branch & i_zero));
    assign o_ir_write   = i_rst_n & w_ir_write;
    assign o_mem_write  = i_rst_n & w_mem_write;
    assign o_reg_write  = i_rst_n & w_reg_write;
    assign o_retire     = i_rst_n & w_retire;
    assign o_illegal_op = i_rst_n & w_illegal_op;
    assign o_adr_src    = w_adr_src;
    assign o_result_src = w_result_src;
    assign o_alu_src_a  = w_alu_src_a;
    assign o_alu_src_b  = w_alu_src_b;
    assign o_alu_op     = w_alu_op;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller; compares the full output vector every cycle.
// Builds with or without MC_JAL_EN.

module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'b0000011;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, retire, illegal_op;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;

    int errors = 0;
    int checks = 0;

    multicycle_controller dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_op(op), .i_zero(zero), .i_mem_ready(mem_ready),
        .o_pc_write(pc_write), .o_adr_src(adr_src), .o_mem_write(mem_write), .o_ir_write(ir_write),
        .o_result_src(result_src), .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b),
        .o_alu_op(alu_op), .o_imm_src(imm_src), .o_reg_write(reg_write), .o_retire(retire),
        .o_illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // Vector order: pw as mw iw rs[2] sa[2] sb[2] ao[2] is[2] rw rt il
    function automatic logic [16:0] ev(input logic pw, input logic as_, input logic mw, input logic iw,
                                       input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [1:0] ao, input logic [1:0] is_, input logic rw,
                                       input logic rt, input logic il);
        return {pw, as_, mw, iw, rs, sa, sb, ao, is_, rw, rt, il};
    endfunction

    function automatic logic [16:0] obs();
        return {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
                alu_op, imm_src, reg_write, retire, illegal_op};
    endfunction

    task automatic chk(input string tag, input logic [16:0] exp_v);
        logic [16:0] o;
        o = obs();
        checks++;
        assert (o === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, o, exp_v);
        end
    endtask

    // Inputs are applied 1 ns after the rising edge; outputs checked at the falling edge.
    task automatic step(input string tag, input logic mr, input logic z, input logic [16:0] exp_v);
        mem_ready = mr;
        zero = z;
        #4;
        chk(tag, exp_v);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset values (op = lw)
        #3;
        chk("reset_idle", ev(0,0,0,0,2'b10,2'b00,2'b10,2'b00,2'b00,0,0,0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // lw, no stalls: 5 cycles
        op = 7'b0000011;
        step("lw_fetch",   1, 0, ev(1,0,0,1,2'b10,2'b00,2'b10,2'b00,2'b00,0,0,0));
        step("lw_decode",  1, 0, ev(0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,0,0,0));
        step("lw_memadr",  1, 0, ev(0,0,0,0,2'b00,2'b10,2'b01,2'b00,2'b00,0,0,0));
        step("lw_memread", 1, 0, ev(0,1,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,0,0,0));
        step("lw_memwb",   1, 0, ev(0,0,0,0,2'b01,2'b00,2'b00,2'b00,2'b00,1,1,0));

        // sw with 3 stall cycles in MEMWRITE
        op = 7'b0100011;
        step("sw_fetch",   1, 0, ev(1,0,0,1,2'b10,2'b00,2'b10,2'b00,2'b01,0,0,0));
        step("sw_decode",  1, 0, ev(0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b01,0,0,0));
        step("sw_memadr",  1, 0, ev(0,0,0,0,2'b00,2'b10,2'b01,2'b00,2'b01,0,0,0));
        step("sw_stall1",  0, 0, ev(0,1,1,0,2'b00,2'b00,2'b00,2'b00,2'b01,0,0,0));
        step("sw_stall2",  0, 0, ev(0,1,1,0,2'b00,2'b00,2'b00,2'b00,2'b01,0,0,0));
        step("sw_stall3",  0, 0, ev(0,1,1,0,2'b00,2'b00,2'b00,2'b00,2'b01,0,0,0));
        step("sw_done",    1, 0, ev(0,1,1,0,2'b00,2'b00,2'b00,2'b00,2'b01,0,1,0));
        step("sw_back_fetch", 1, 0, ev(1,0,0,1,2'b10,2'b00,2'b10,2'b00,2'b01,0,0,0));

        // sw abandoned by reset in a MEMWRITE stall (continues from DECODE above)
        step("sw2_decode", 1, 0, ev(0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b01,0,0,0));
        step("sw2_memadr", 1, 0, ev(0,0,0,0,2'b00,2'b10,2'b01,2'b00,2'b01,0,0,0));
        mem_ready = 1'b0;
        #4;
        chk("sw2_stall", ev(0,1,1,0,2'b00,2'b00,2'b00,2'b00,2'b01,0,0,0));
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async", ev(0,0,0,0,2'b10,2'b00,2'b10,2'b00,2'b01,0,0,0));
        @(posedge clk); #1;
        chk("rst_hold", ev(0,0,0,0,2'b10,2'b00,2'b10,2'b00,2'b01,0,0,0));
        rst_n = 1'b1;
        step("rst_fetch_stall", 0, 0, ev(0,0,0,0,2'b10,2'b00,2'b10,2'b00,2'b01,0,0,0));

        // R-type then I-type back to back; first ir_write after reset here
        op = 7'b0110011;
        step("r_fetch",  1, 0, ev(1,0,0,1,2'b10,2'b00,2'b10,2'b00,2'b00,0,0,0));
        step("r_decode", 1, 0, ev(0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,0,0,0));
        step("r_exec",   1, 0, ev(0,0,0,0,2'b00,2'b10,2'b00,2'b10,2'b00,0,0,0));
        step("r_aluwb",  1, 0, ev(0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,1,1,0));
        op = 7'b0010011;
        step("i_fetch",  1, 0, ev(1,0,0,1,2'b10,2'b00,2'b10,2'b00,2'b00,0,0,0));
        step("i_decode", 1, 0, ev(0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,0,0,0));
        step("i_exec",   1, 0, ev(0,0,0,0,2'b00,2'b10,2'b01,2'b11,2'b00,0,0,0));
        step("i_aluwb",  1, 0, ev(0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,1,1,0));

        // beq taken, then not taken with zero high outside the BEQ cycle
        op = 7'b1100011;
        step("beq1_fetch",  1, 0, ev(1,0,0,1,2'b10,2'b00,2'b10,2'b00,2'b10,0,0,0));
        step("beq1_decode", 1, 0, ev(0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b10,0,0,0));
        step("beq1_taken",  1, 1, ev(1,0,0,0,2'b00,2'b10,2'b00,2'b01,2'b10,0,1,0));
        step("beq2_fetch",  1, 1, ev(1,0,0,1,2'b10,2'b00,2'b10,2'b00,2'b10,0,0,0));
        step("beq2_decode", 1, 1, ev(0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b10,0,0,0));
        step("beq2_not",    1, 0, ev(0,0,0,0,2'b00,2'b10,2'b00,2'b01,2'b10,0,1,0));

        // unsupported opcode
        op = 7'b1111111;
        step("ill_fetch",  1, 0, ev(1,0,0,1,2'b10,2'b00,2'b10,2'b00,2'b00,0,0,0));
        step("ill_decode", 1, 0, ev(0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,0,1,1));

        // jal opcode
        op = 7'b1101111;
`ifdef MC_JAL_EN
        step("jal_fetch",  1, 0, ev(1,0,0,1,2'b10,2'b00,2'b10,2'b00,2'b11,0,0,0));
        step("jal_decode", 1, 0, ev(0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b11,0,0,0));
        step("jal_jal",    1, 0, ev(1,0,0,0,2'b00,2'b01,2'b10,2'b00,2'b11,0,0,0));
        step("jal_aluwb",  1, 0, ev(0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b11,1,1,0));
`else
        step("jal_fetch",  1, 0, ev(1,0,0,1,2'b10,2'b00,2'b10,2'b00,2'b00,0,0,0));
        step("jal_decode", 1, 0, ev(0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,0,1,1));
`endif

        // lw with one stall cycle in MEMREAD (starts in FETCH)
        op = 7'b0000011;
        step("lw2_fetch",   1, 0, ev(1,0,0,1,2'b10,2'b00,2'b10,2'b00,2'b00,0,0,0));
        step("lw2_decode",  1, 0, ev(0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,0,0,0));
        step("lw2_memadr",  1, 0, ev(0,0,0,0,2'b00,2'b10,2'b01,2'b00,2'b00,0,0,0));
        step("lw2_stall",   0, 0, ev(0,1,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,0,0,0));
        step("lw2_memread", 1, 0, ev(0,1,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,0,0,0));
        step("lw2_memwb",   1, 0, ev(0,0,0,0,2'b01,2'b00,2'b00,2'b00,2'b00,1,1,0));
        step("lw2_end_fetch", 0, 0, ev(0,0,0,0,2'b10,2'b00,2'b10,2'b00,2'b00,0,0,0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
